morse_word_uart_tx: RTL and testbench

Downstream consumer of the Morse capture-and-decode word stage. On each rising edge of `word_ended`, snapshots the decoded word and error flag and transmits it as ASCII over a UART 8N1 line: non-blank characters, `!` if error, then CR LF. Gives the board a host-visible log of decoded words, independent of the display path.

---
 rtl/morse_word_uart_tx_pkg.sv | 33 +++
 rtl/morse_word_uart_tx_if.sv | 15 +
 rtl/morse_word_uart_tx_byte.sv | 53 +++++
 rtl/morse_word_uart_tx.sv | 141 ++++++++++++++
 tb/tb_morse_word_uart_tx.sv | 207 ++++++++++++++++++++
 5 files changed

// File: rtl/morse_word_uart_tx_pkg.sv
// rtl/morse_word_uart_tx_pkg.sv - shared constants, controller states and Morse code to ASCII map
// Holds the word geometry (CHAR_W, MAX_CHARS), the ASCII suffix bytes and char_to_ascii().
package morse_word_uart_tx_pkg;

  localparam int CHAR_W    = 6;
  localparam int MAX_CHARS = 6;
  localparam int IDX_W     = $clog2(MAX_CHARS);

  localparam logic [7:0] ASCII_CR    = 8'h0D;
  localparam logic [7:0] ASCII_LF    = 8'h0A;
  localparam logic [7:0] ASCII_ERR   = 8'h21;
  localparam logic [7:0] ASCII_SPACE = 8'h20;
  localparam logic [7:0] ASCII_STAR  = 8'h2A;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SKIP,
    ST_CHARS,
    ST_SUFFIX,
    ST_DRAIN
  } ctrl_state_t;

  // 0 -> space, 1..26 -> 'A'..'Z', 27..36 -> '0'..'9', anything else -> '*'
  function automatic logic [7:0] char_to_ascii(input logic [CHAR_W-1:0] code);
    logic [7:0] c8;
    c8 = 8'(code);
    if (c8 == 8'd0)       return ASCII_SPACE;
    else if (c8 <= 8'd26) return 8'h40 + c8;
    else if (c8 <= 8'd36) return c8 + 8'd21;
    else                  return ASCII_STAR;
  endfunction

endpackage

// File: rtl/morse_word_uart_tx_if.sv
// rtl/morse_word_uart_tx_if.sv - word input and UART status bundle
// master: drives word/word_ended/error, observes tx/busy/overrun. slave: the transmitter.
interface morse_word_uart_tx_if;
  import morse_word_uart_tx_pkg::*;

  logic [CHAR_W*MAX_CHARS-1:0] word;
  logic                        word_ended;
  logic                        error;
  logic                        tx;
  logic                        busy;
  logic                        overrun;

  modport master (output word, word_ended, error, input tx, busy, overrun);
  modport slave  (input word, word_ended, error, output tx, busy, overrun);
endinterface

// File: rtl/morse_word_uart_tx_byte.sv
// rtl/morse_word_uart_tx_byte.sv - 8N1 UART byte serializer
// Ports: clk, rst_n (sync, active-low), data/valid/ready byte handshake, tx line (idle high).
module uart_tx_byte #(
  parameter int CLK_DIV = 434
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] data,
  input  logic       valid,
  output logic       ready,
  output logic       tx
);
  localparam int              TW      = $clog2(CLK_DIV);
  localparam logic [TW-1:0]   BIT_TOP = TW'(CLK_DIV - 1);

  logic          active_q;
  logic [3:0]    bit_q;     // 0 start, 1..8 data, 9 stop
  logic [TW-1:0] timer_q;
  logic [7:0]    data_q;
  logic          tx_q;

  // Accepting in the final stop cycle lets frames run back to back.
  assign ready = ~active_q | ((bit_q == 4'd9) && (timer_q == '0));
  assign tx    = tx_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      active_q <= 1'b0;
      bit_q    <= '0;
      timer_q  <= '0;
      data_q   <= '0;
      tx_q     <= 1'b1;
    end else if (valid && ready) begin
      active_q <= 1'b1;
      bit_q    <= '0;
      timer_q  <= BIT_TOP;
      data_q   <= data;
      tx_q     <= 1'b0;
    end else if (active_q) begin
      if (timer_q == '0) begin
        if (bit_q == 4'd9) begin
          active_q <= 1'b0;
        end else begin
          bit_q   <= bit_q + 4'd1;
          timer_q <= BIT_TOP;
          tx_q    <= (bit_q == 4'd8) ? 1'b1 : data_q[bit_q[2:0]];
        end
      end else begin
        timer_q <= timer_q - 1'b1;
      end
    end
  end
endmodule

// File: rtl/morse_word_uart_tx.sv
// rtl/morse_word_uart_tx.sv - logs each decoded Morse word as ASCII over UART 8N1
// Ports: clk, rst_n (sync, active-low), bus (slave): word/word_ended/error in, tx/busy/overrun out.
module morse_word_uart_tx #(
  parameter int CLK_DIV  = 434,
  parameter bit ERR_MARK = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  morse_word_uart_tx_if.slave  bus
);
  import morse_word_uart_tx_pkg::*;

  localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(MAX_CHARS - 1);

  ctrl_state_t                 state_q;
  logic                        we_q;
  logic                        busy_q;
  logic                        overrun_q;
  logic [IDX_W-1:0]            idx_q;
  logic [1:0]                  sfx_q;   // 0 '!', 1 CR, 2 LF
  logic [CHAR_W*MAX_CHARS-1:0] snap_q;

  logic             rise;
  logic             byte_valid;
  logic             byte_ready;
  logic             accept;
  logic             ser_tx;
  logic [7:0]       byte_data;
  logic [7:0]       sfx_byte;
  logic [CHAR_W-1:0] cur_ch;

  assign rise        = bus.word_ended & ~we_q;
  assign cur_ch      = snap_q[int'(idx_q)*CHAR_W +: CHAR_W];
  assign accept      = byte_valid & byte_ready;
  assign bus.tx      = ser_tx;
  assign bus.busy    = busy_q;
  assign bus.overrun = overrun_q;

  always_comb begin
    case (sfx_q)
      2'd0:    sfx_byte = ASCII_ERR;
      2'd1:    sfx_byte = ASCII_CR;
      default: sfx_byte = ASCII_LF;
    endcase
  end

  // SKIP already offers the first byte (a char, or the suffix for an all-blank
  // word) so blank-skipping costs exactly one cycle per leading blank.
  always_comb begin
    byte_valid = 1'b0;
    byte_data  = sfx_byte;
    case (state_q)
      ST_SKIP: begin
        if (cur_ch != '0) begin
          byte_valid = 1'b1;
          byte_data  = char_to_ascii(cur_ch);
        end else if (idx_q == '0) begin
          byte_valid = 1'b1;
        end
      end
      ST_CHARS: begin
        byte_valid = 1'b1;
        byte_data  = char_to_ascii(cur_ch);
      end
      ST_SUFFIX: byte_valid = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      we_q      <= 1'b1;   // a level already high at reset release is not a rise
      busy_q    <= 1'b0;
      overrun_q <= 1'b0;
      idx_q     <= '0;
      sfx_q     <= '0;
      snap_q    <= '0;
    end else begin
      we_q      <= bus.word_ended;
      overrun_q <= rise & busy_q;
      case (state_q)
        ST_IDLE: begin
          if (rise) begin
            snap_q  <= bus.word;
            idx_q   <= IDX_TOP;
            sfx_q   <= (ERR_MARK && bus.error) ? 2'd0 : 2'd1;
            busy_q  <= 1'b1;
            state_q <= ST_SKIP;
          end
        end
        ST_SKIP: begin
          if (accept) begin
            if (cur_ch != '0) begin
              if (idx_q == '0) begin
                state_q <= ST_SUFFIX;
              end else begin
                idx_q   <= idx_q - 1'b1;
                state_q <= ST_CHARS;
              end
            end else begin
              sfx_q   <= sfx_q + 2'd1;
              state_q <= ST_SUFFIX;
            end
          end else if (cur_ch == '0 && idx_q != '0) begin
            idx_q <= idx_q - 1'b1;
          end
        end
        ST_CHARS: begin
          if (accept) begin
            if (idx_q == '0) state_q <= ST_SUFFIX;
            else             idx_q   <= idx_q - 1'b1;
          end
        end
        ST_SUFFIX: begin
          if (accept) begin
            if (sfx_q == 2'd2) state_q <= ST_DRAIN;
            else               sfx_q   <= sfx_q + 2'd1;
          end
        end
        ST_DRAIN: begin
          // ready only rises in the LF frame's last stop cycle here
          if (byte_ready) begin
            busy_q  <= 1'b0;
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  uart_tx_byte #(.CLK_DIV(CLK_DIV)) u_ser (
    .clk   (clk),
    .rst_n (rst_n),
    .data  (byte_data),
    .valid (byte_valid),
    .ready (byte_ready),
    .tx    (ser_tx)
  );
endmodule

// File: tb/tb_morse_word_uart_tx.sv
// tb/tb_morse_word_uart_tx.sv - directed bench for morse_word_uart_tx with exact-timing UART receiver
module tb_morse_word_uart_tx;
  import morse_word_uart_tx_pkg::*;

  localparam int CLK_DIV = 4;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  morse_word_uart_tx_if bus1 ();
  morse_word_uart_tx_if bus0 ();

  morse_word_uart_tx #(.CLK_DIV(CLK_DIV), .ERR_MARK(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus1)
  );
  morse_word_uart_tx #(.CLK_DIV(CLK_DIV), .ERR_MARK(1'b0)) dut0 (
    .clk(clk), .rst_n(rst_n), .bus(bus0)
  );

  int checks = 0;
  int errors = 0;
  int ov_cnt = 0;
  logic [7:0] exp_q[$];

  always @(negedge clk) if (rst_n === 1'b1 && bus1.overrun === 1'b1) ov_cnt++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic tx_of(input int sel);
    return (sel == 0) ? bus1.tx : bus0.tx;
  endfunction

  function automatic logic busy_of(input int sel);
    return (sel == 0) ? bus1.busy : bus0.busy;
  endfunction

  function automatic logic [35:0] mk(input int c5, c4, c3, c2, c1, c0);
    return {6'(c5), 6'(c4), 6'(c3), 6'(c2), 6'(c1), 6'(c0)};
  endfunction

  task automatic drive(input logic [35:0] w, input logic e, input logic we);
    bus1.word = w; bus1.error = e; bus1.word_ended = we;
    bus0.word = w; bus0.error = e; bus0.word_ended = we;
  endtask

  task automatic set_we(input logic we);
    bus1.word_ended = we;
    bus0.word_ended = we;
  endtask

  // Rise seen in the cycle the inputs are driven; returns at the next negedge (N+1).
  task automatic send_word(input logic [35:0] w, input logic e, input logic hold, input string tag);
    drive(w, e, 1'b1);
    @(negedge clk);
    check({tag, "_busy_rise"}, 32'(bus1.busy), 32'd1);
    if (!hold) set_we(1'b0);
  endtask

  task automatic wait_start(input int sel, input int exp_c, input string tag);
    int c;
    c = 1;
    while (tx_of(sel) !== 1'b0 && c < 200) begin
      @(negedge clk);
      c++;
    end
    check({tag, "_start_lat"}, 32'(c), 32'(exp_c));
  endtask

  // Every cycle of every bit is compared, so any timing slip or gap shows up.
  task automatic rx_check(input int sel, input string tag);
    logic [7:0] e, obs;
    logic       eb, s;
    int         bad, busy_lo;
    busy_lo = 0;
    for (int i = 0; i < exp_q.size(); i++) begin
      e = exp_q[i];
      obs = '0;
      bad = 0;
      for (int b = 0; b < 10; b++) begin
        eb = (b == 0) ? 1'b0 : (b == 9) ? 1'b1 : e[b-1];
        for (int k = 0; k < CLK_DIV; k++) begin
          s = tx_of(sel);
          if (s !== eb) bad++;
          if (busy_of(sel) !== 1'b1) busy_lo++;
          if (b >= 1 && b <= 8 && k == CLK_DIV/2) obs[b-1] = s;
          @(negedge clk);
        end
      end
      check($sformatf("%s_byte%0d", tag, i), 32'(obs), 32'(e));
      check($sformatf("%s_timing%0d", tag, i), 32'(bad), 32'd0);
    end
    check({tag, "_busy_held"}, 32'(busy_lo), 32'd0);
    check({tag, "_busy_fall"}, 32'(busy_of(sel)), 32'd0);
    check({tag, "_tx_idle"}, 32'(tx_of(sel)), 32'd1);
  endtask

  task automatic watch_quiet(input int n, input string tag);
    int lows, busys;
    lows = 0;
    busys = 0;
    repeat (n) begin
      @(negedge clk);
      if (bus1.tx !== 1'b1) lows++;
      if (bus1.busy !== 1'b0) busys++;
    end
    check({tag, "_tx_low"}, 32'(lows), 32'd0);
    check({tag, "_busy"}, 32'(busys), 32'd0);
  endtask

  initial begin
    int ov0;
    rst_n = 1'b0;
    drive('0, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    check("rst_tx", 32'(bus1.tx), 32'd1);
    check("rst_busy", 32'(bus1.busy), 32'd0);
    check("rst_overrun", 32'(bus1.overrun), 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // "     A": five leading blanks skipped
    exp_q = '{8'h41, 8'h0D, 8'h0A};
    send_word(mk(0, 0, 0, 0, 0, 1), 1'b0, 1'b0, "w1");
    wait_start(0, 7, "w1");
    rx_check(0, "w1");

    // "ABBCCC": eight back-to-back frames
    ov0 = ov_cnt;
    exp_q = '{8'h41, 8'h42, 8'h42, 8'h43, 8'h43, 8'h43, 8'h0D, 8'h0A};
    send_word(mk(1, 2, 2, 3, 3, 3), 1'b0, 1'b0, "w2");
    wait_start(0, 2, "w2");
    rx_check(0, "w2");
    check("w2_no_overrun", 32'(ov_cnt - ov0), 32'd0);

    // "  ABCD" with error, ERR_MARK=1 then ERR_MARK=0
    exp_q = '{8'h41, 8'h42, 8'h43, 8'h44, 8'h21, 8'h0D, 8'h0A};
    send_word(mk(0, 0, 1, 2, 3, 4), 1'b1, 1'b0, "w3");
    wait_start(0, 4, "w3");
    rx_check(0, "w3");
    exp_q = '{8'h41, 8'h42, 8'h43, 8'h44, 8'h0D, 8'h0A};
    send_word(mk(0, 0, 1, 2, 3, 4), 1'b1, 1'b0, "w3n");
    wait_start(1, 4, "w3n");
    rx_check(1, "w3n");
    repeat (60) @(negedge clk);

    // all blank
    exp_q = '{8'h0D, 8'h0A};
    send_word(mk(0, 0, 0, 0, 0, 0), 1'b0, 1'b0, "w4");
    wait_start(0, 7, "w4");
    rx_check(0, "w4");

    // " A *B ": interior/trailing blanks as space, code 40 as '*'
    exp_q = '{8'h41, 8'h20, 8'h2A, 8'h42, 8'h20, 8'h0D, 8'h0A};
    send_word(mk(0, 1, 0, 40, 2, 0), 1'b0, 1'b0, "w5");
    wait_start(0, 3, "w5");
    rx_check(0, "w5");

    // "09Z  A": digit and letter range edges
    exp_q = '{8'h30, 8'h39, 8'h5A, 8'h20, 8'h20, 8'h41, 8'h0D, 8'h0A};
    send_word(mk(27, 36, 26, 0, 0, 1), 1'b0, 1'b0, "w6");
    wait_start(0, 2, "w6");
    rx_check(0, "w6");

    // second rise mid-transfer with new word/error: dropped, first word intact
    ov0 = ov_cnt;
    exp_q = '{8'h41, 8'h42, 8'h42, 8'h43, 8'h43, 8'h43, 8'h0D, 8'h0A};
    send_word(mk(1, 2, 2, 3, 3, 3), 1'b0, 1'b0, "ov");
    fork
      begin
        wait_start(0, 2, "ov");
        rx_check(0, "ov");
      end
      begin
        repeat (50) @(negedge clk);
        drive(mk(9, 9, 9, 9, 9, 9), 1'b1, 1'b1);
        @(negedge clk);
        set_we(1'b0);
      end
    join
    check("ov_pulse_cycles", 32'(ov_cnt - ov0), 32'd1);
    watch_quiet(60, "ov_quiet");

    // reset during data bit 3 of byte 2, word_ended held high through release
    send_word(mk(1, 2, 2, 3, 3, 3), 1'b0, 1'b1, "rs");
    wait_start(0, 2, "rs");
    repeat (57) @(negedge clk);
    check("rs_pre_tx", 32'(bus1.tx), 32'd0);
    rst_n = 1'b0;
    @(negedge clk);
    check("rs_tx", 32'(bus1.tx), 32'd1);
    check("rs_busy", 32'(bus1.busy), 32'd0);
    rst_n = 1'b1;
    watch_quiet(100, "rs_quiet");
    set_we(1'b0);
    repeat (3) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
